// File: rtl/ccc_lock_reset_seq.sv
// Lock-qualified reset sequencer: filters the CCC LOCK, times the hold and the
// core/peripheral release stagger, and tracks run-time lock-loss events.
module ccc_lock_reset_seq #(
  parameter int LOCK_FILTER    = 16,
  parameter int HOLD_CYCLES    = 64,
  parameter int STAGGER_CYCLES = 8,
  parameter int LOSS_FILTER    = 4
) (
  input  logic       PCLK,
  input  logic       PRESERN,
  input  logic       LOCK,
  input  logic       SW_RESET,
  input  logic       CLR_FLAG,
  output logic       CORE_RESET_N,
  output logic       PERIPH_RESET_N,
  output logic       READY,
  output logic       LOSS_FLAG,
  output logic [7:0] LOSS_COUNT,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'b00,
    S_HOLD      = 2'b01,
    S_STAGGER   = 2'b10,
    S_RUN       = 2'b11
  } state_t;

  localparam logic [7:0] C_LOCK_M1 = 8'(LOCK_FILTER - 1);
  localparam logic [7:0] C_HOLD_M1 = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] C_STAG_M1 = 8'(STAGGER_CYCLES - 1);
  localparam logic [7:0] C_LOSS_M1 = 8'(LOSS_FILTER - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_low_cnt;
  logic       r_sync1;
  logic       r_lock_s;
  logic       r_core_n;
  logic       r_periph_n;
  logic       r_ready;
  logic       r_flag;
  logic [7:0] r_count;
  logic       w_loss;

  // LOCK is asynchronous to PCLK; this pair is its only path into the logic.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= LOCK;
      r_lock_s <= r_sync1;
    end
  end

  // STAGGER keeps cnt for release timing, so its low-run count lives in r_low_cnt.
  assign w_loss = !SW_RESET && !r_lock_s &&
                  (((r_state == S_RUN) && (r_cnt == C_LOSS_M1)) ||
                   ((r_state == S_STAGGER) && (r_low_cnt == C_LOSS_M1)));

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_state    <= S_WAIT_LOCK;
      r_cnt      <= 8'd0;
      r_low_cnt  <= 8'd0;
      r_core_n   <= 1'b0;
      r_periph_n <= 1'b0;
      r_ready    <= 1'b0;
      r_flag     <= 1'b0;
      r_count    <= 8'd0;
    end else begin
      if (w_loss) begin
        r_flag <= 1'b1;
      end else if (CLR_FLAG) begin
        r_flag <= 1'b0;
      end
      if (w_loss && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end

      case (r_state)
        S_WAIT_LOCK: begin
          r_low_cnt <= 8'd0;
          if (SW_RESET || !r_lock_s) begin
            r_cnt <= 8'd0;
          end else if (r_cnt == C_LOCK_M1) begin
            r_state <= S_HOLD;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (SW_RESET || !r_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= 8'd0;
          end else if (r_cnt == C_HOLD_M1) begin
            r_state  <= S_STAGGER;
            r_cnt    <= 8'd0;
            r_core_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_STAGGER: begin
          if (SW_RESET || w_loss) begin
            r_state   <= S_WAIT_LOCK;
            r_cnt     <= 8'd0;
            r_low_cnt <= 8'd0;
            r_core_n  <= 1'b0;
          end else if (r_cnt == C_STAG_M1) begin
            r_state    <= S_RUN;
            r_cnt      <= 8'd0;
            r_low_cnt  <= 8'd0;
            r_periph_n <= 1'b1;
            r_ready    <= 1'b1;
          end else begin
            r_cnt     <= r_cnt + 8'd1;
            r_low_cnt <= r_lock_s ? 8'd0 : r_low_cnt + 8'd1;
          end
        end
        S_RUN: begin
          if (SW_RESET || w_loss) begin
            r_state    <= S_WAIT_LOCK;
            r_cnt      <= 8'd0;
            r_core_n   <= 1'b0;
            r_periph_n <= 1'b0;
            r_ready    <= 1'b0;
          end else if (r_lock_s) begin
            r_cnt <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= S_WAIT_LOCK;
          r_cnt      <= 8'd0;
          r_low_cnt  <= 8'd0;
          r_core_n   <= 1'b0;
          r_periph_n <= 1'b0;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

  assign CORE_RESET_N   = r_core_n;
  assign PERIPH_RESET_N = r_periph_n;
  assign READY          = r_ready;
  assign LOSS_FLAG      = r_flag;
  assign LOSS_COUNT     = r_count;
  assign STATE          = r_state;

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Bench for ccc_lock_reset_seq: directed scenarios plus random LOCK traffic,
// every cycle compared against a phase/run-length model of the sequencer.
module tb_ccc_lock_reset_seq;

  localparam int LF = 16, HC = 64, SC = 8, LS = 4;

  logic       PCLK = 1'b0;
  logic       PRESERN = 1'b0;
  logic       LOCK = 1'b0;
  logic       SW_RESET = 1'b0;
  logic       CLR_FLAG = 1'b0;
  logic       CORE_RESET_N, PERIPH_RESET_N, READY, LOSS_FLAG;
  logic [7:0] LOSS_COUNT;
  logic [1:0] STATE;

  int n_vec = 0;
  int n_bad = 0;

  ccc_lock_reset_seq dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .LOCK(LOCK), .SW_RESET(SW_RESET),
    .CLR_FLAG(CLR_FLAG), .CORE_RESET_N(CORE_RESET_N),
    .PERIPH_RESET_N(PERIPH_RESET_N), .READY(READY), .LOSS_FLAG(LOSS_FLAG),
    .LOSS_COUNT(LOSS_COUNT), .STATE(STATE)
  );

  always #5 PCLK = ~PCLK;

  // Model: phase 0 waiting for lock, 1 holding, 2 staggering, 3 running.
  bit m_s1, m_s2, m_flag;
  int m_phase, m_highs, m_age, m_lows, m_count;

  function automatic void m_reset();
    m_s1 = 0; m_s2 = 0; m_flag = 0;
    m_phase = 0; m_highs = 0; m_age = 0; m_lows = 0; m_count = 0;
  endfunction

  function automatic void m_enter(int p);
    m_phase = p; m_highs = 0; m_age = 0; m_lows = 0;
  endfunction

  function automatic void m_step(bit lock, bit sw, bit clr);
    bit ls, loss;
    ls = m_s2; m_s2 = m_s1; m_s1 = lock; loss = 0;
    if (sw) begin
      if (m_phase == 0) m_highs = 0; else m_enter(0);
    end else begin
      case (m_phase)
        0: begin
          m_highs = ls ? m_highs + 1 : 0;
          if (m_highs == LF) m_enter(1);
        end
        1: begin
          m_age++;
          if (!ls) m_enter(0);
          else if (m_age == HC) m_enter(2);
        end
        2: begin
          m_age++;
          m_lows = ls ? 0 : m_lows + 1;
          if (m_lows == LS) begin loss = 1; m_enter(0); end
          else if (m_age == SC) m_enter(3);
        end
        default: begin
          m_lows = ls ? 0 : m_lows + 1;
          if (m_lows == LS) begin loss = 1; m_enter(0); end
        end
      endcase
    end
    if (loss) m_flag = 1; else if (clr) m_flag = 0;
    if (loss && m_count < 255) m_count++;
  endfunction

  function automatic logic [13:0] exp_vec();
    return {m_phase >= 2, m_phase == 3, m_phase == 3, m_flag, 8'(m_count), 2'(m_phase)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {CORE_RESET_N, PERIPH_RESET_N, READY, LOSS_FLAG, LOSS_COUNT, STATE};
  endfunction

  // One clock: drive inputs, step model at the edge, sample 1 time unit later.
  task automatic tick(input bit lock, input bit sw, input bit clr);
    LOCK = lock; SW_RESET = sw; CLR_FLAG = clr;
    @(posedge PCLK);
    m_step(lock, sw, clr);
    #1;
    SW_RESET = 0; CLR_FLAG = 0;
  endtask

  task automatic do_reset(input bit lock);
    LOCK = lock; SW_RESET = 0; CLR_FLAG = 0;
    PRESERN = 0;
    repeat (3) @(posedge PCLK);
    m_reset();
    @(negedge PCLK);
    PRESERN = 1;
  endtask

  task automatic test_reset();
    PRESERN = 0; LOCK = 1;
    #3;
    n_vec++;
    if (dut_vec() !== 14'd0) begin
      n_bad++; $display("FAIL reset_vals got %h want %h", dut_vec(), 14'd0);
    end
    do_reset(1);
    #1;
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_release got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_startup();
    int core_edge = -1, per_edge = -1;
    do_reset(1);
    for (int i = 1; i <= 100; i++) begin
      tick(1, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL startup cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (CORE_RESET_N && core_edge < 0) core_edge = i;
      if (PERIPH_RESET_N && per_edge < 0) per_edge = i;
    end
    n_vec++;
    if (core_edge != 2 + LF + HC) begin
      n_bad++; $display("FAIL core_latency got %0d want %0d", core_edge, 2 + LF + HC);
    end
    n_vec++;
    if (per_edge != 2 + LF + HC + SC) begin
      n_bad++; $display("FAIL periph_latency got %0d want %0d", per_edge, 2 + LF + HC + SC);
    end
  endtask

  task automatic test_hold_glitch();
    int core_edge = -1;
    do_reset(1);
    for (int i = 1; i <= 160; i++) begin
      tick(i != 58, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL hold_glitch cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (CORE_RESET_N && core_edge < 0) core_edge = i;
    end
    n_vec++;
    if (core_edge != 140 || LOSS_COUNT !== 8'd0) begin
      n_bad++; $display("FAIL hold_glitch_retime got edge %0d cnt %0d want edge 140 cnt 0",
                        core_edge, LOSS_COUNT);
    end
  endtask

  task automatic test_run_loss();
    bit pat[$];
    for (int i = 0; i < 3; i++) pat.push_back(0);
    for (int i = 0; i < 10; i++) pat.push_back(1);
    for (int i = 0; i < 4; i++) pat.push_back(0);
    for (int i = 0; i < 8; i++) pat.push_back(1);
    for (int i = 0; i < pat.size(); i++) begin
      tick(pat[i], 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL run_loss step %0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i == 12) begin
        n_vec++;
        if (READY !== 1'b1) begin
          n_bad++; $display("FAIL short_dip_ready got %b want 1", READY);
        end
      end
    end
    n_vec++;
    if ({CORE_RESET_N, PERIPH_RESET_N, LOSS_FLAG, LOSS_COUNT} !== {1'b0, 1'b0, 1'b1, 8'd1}) begin
      n_bad++; $display("FAIL loss_event got c%b p%b f%b n%0d want c0 p0 f1 n1",
                        CORE_RESET_N, PERIPH_RESET_N, LOSS_FLAG, LOSS_COUNT);
    end
  endtask

  task automatic test_sw_reset();
    logic [7:0] cnt_before;
    for (int i = 0; i < 100; i++) tick(1, 0, 0);
    cnt_before = LOSS_COUNT;
    tick(1, 1, 0);
    n_vec++;
    if ({CORE_RESET_N, PERIPH_RESET_N, READY, STATE} !== 5'd0 || LOSS_COUNT !== cnt_before) begin
      n_bad++; $display("FAIL sw_reset got %h want resets 0 cnt %0d", dut_vec(), cnt_before);
    end
    for (int i = 1; i <= 100; i++) begin
      tick(1, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL sw_reseq cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturate();
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < 96; i++) tick(1, 0, 0);
      for (int i = 0; i < 6; i++) tick(0, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL saturate iter %0d got %h want %h", it, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (LOSS_COUNT !== 8'd255) begin
      n_bad++; $display("FAIL saturate_255 got %0d want 255", LOSS_COUNT);
    end
    // CLR_FLAG held every cycle of a loss window lands on the loss edge too.
    for (int i = 0; i < 96; i++) tick(1, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 1);
    n_vec++;
    if (LOSS_FLAG !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL clr_vs_loss got flag %b vec %h want flag 1 vec %h",
                        LOSS_FLAG, dut_vec(), exp_vec());
    end
    tick(0, 0, 1);
    n_vec++;
    if (LOSS_FLAG !== 1'b0) begin
      n_bad++; $display("FAIL clr_flag got %b want 0", LOSS_FLAG);
    end
  endtask

  task automatic test_preset_stagger();
    do_reset(1);
    for (int i = 0; i < 85; i++) tick(1, 0, 0);
    n_vec++;
    if (STATE !== 2'b10) begin
      n_bad++; $display("FAIL in_stagger got %b want 10", STATE);
    end
    #2 PRESERN = 0;
    #1;
    n_vec++;
    if (dut_vec() !== 14'd0) begin
      n_bad++; $display("FAIL async_reset got %h want 0", dut_vec());
    end
  endtask

  task automatic test_random();
    bit lk = 1;
    int run_left = 0;
    do_reset(1);
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        lk = ~lk;
        run_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(20, 140);
      end
      run_left--;
      tick(lk, $urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_hold_glitch();
    do_reset(1);
    for (int i = 0; i < 100; i++) tick(1, 0, 0);
    test_run_loss();
    test_sw_reset();
    test_saturate();
    test_preset_stagger();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
